// File: rtl/apb_master_param.sv
// rtl/apb_master_param.sv - queued APB4 master: command FIFO feeding back-to-back transfers with PREADY timeout

module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   PCLK,
  input  logic                   PRESET_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: nothing is read until count says it was written.
  always_ff @(posedge PCLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module apb_master_param #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_W-1:0]             cmd_addr,
  input  logic [DATA_W-1:0]             cmd_wdata,
  input  logic [DATA_W/8-1:0]           cmd_strb,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          rsp_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          PSEL_o,
  output logic                          PENABLE_o,
  output logic [ADDR_W-1:0]             PADDR_o,
  output logic                          PWRITE_o,
  output logic [DATA_W-1:0]             PWDATA_o,
  output logic [DATA_W/8-1:0]           PSTRB_o,
  input  logic [DATA_W-1:0]             PRDATA_i,
  input  logic                          PREADY_i,
  input  logic                          PSLVERR_i
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  state_t            state;
  state_t            state_d;
  cmd_t              push_cmd;
  cmd_t              head_cmd;
  logic [$bits(cmd_t)-1:0] head_bits;
  logic              fifo_pop;
  logic              xfer_done;
  logic              xfer_abort;
  logic [TO_W-1:0]   wait_cnt;

  assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};
  assign head_cmd  = cmd_t'(head_bits);
  assign cmd_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign busy      = (state != IDLE) || (fifo_count != '0);

  apb_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .PCLK      (PCLK),
    .PRESET_n  (PRESET_n),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (head_bits),
    .count     (fifo_count)
  );

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // A ready slave always wins over the timeout on the same edge.
  always_comb begin
    state_d    = state;
    fifo_pop   = 1'b0;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          fifo_pop = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY_i) begin
          xfer_done = 1'b1;
        end else if ((TIMEOUT != 0) && (wait_cnt == TO_W'(TIMEOUT))) begin
          xfer_abort = 1'b1;
        end
        if (xfer_done || xfer_abort) begin
          if (fifo_count != '0) begin
            fifo_pop = 1'b1;
            state_d  = SETUP;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs only change when a command is loaded, so they stay stable through ACCESS.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      PSEL_o    <= 1'b0;
      PENABLE_o <= 1'b0;
      PADDR_o   <= '0;
      PWRITE_o  <= 1'b0;
      PWDATA_o  <= '0;
      PSTRB_o   <= '0;
    end else if (fifo_pop) begin
      PSEL_o    <= 1'b1;
      PENABLE_o <= 1'b0;
      PADDR_o   <= head_cmd.addr;
      PWRITE_o  <= head_cmd.write;
      if (head_cmd.write) begin
        PWDATA_o <= head_cmd.wdata;
        PSTRB_o  <= head_cmd.strb;
      end else begin
        PSTRB_o  <= '0;
      end
    end else if (state == SETUP) begin
      PENABLE_o <= 1'b1;
    end else if (xfer_done || xfer_abort) begin
      PSEL_o    <= 1'b0;
      PENABLE_o <= 1'b0;
    end
  end

  // The wait counter saturates at TIMEOUT; with TIMEOUT = 0 it never leaves zero.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      wait_cnt <= '0;
    end else if ((state != ACCESS) || xfer_done || xfer_abort) begin
      wait_cnt <= '0;
    end else if (wait_cnt != TO_W'(TIMEOUT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (xfer_done) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= PWRITE_o ? '0 : PRDATA_i;
        rsp_err     <= PSLVERR_i;
        rsp_timeout <= 1'b0;
      end else if (xfer_abort) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule
